tinker_prog_loader: RTL and testbench
=====================================

Name: tinker_prog_loader

Overview:
- Byte-stream program loader that writes the instruction image which the Tinker core's fetch path later reads.
- It accepts a framed byte stream over a valid/ready handshake and writes each byte into data memory, little-endian and in order, starting at BASE_ADDR.
- It verifies an XOR checksum and holds the core in reset until the load succeeds.
- It sits beside tinker_core and drives the memory byte-write port and the core's hold/reset input.

Parameters:
- BASE_ADDR, 32'h2000, byte address of the first instruction byte; matches the core's reset PC.
- MEM_SIZE, 524288, memory size in bytes; used for the bounds check.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- s_valid  input  1  stream byte valid.
- s_data  input  8  stream byte.
- s_ready  output  1  loader can accept a byte this cycle.
- restart  input  1  single-cycle pulse; starts a new load from DONE or ERR.
- mem_we  output  1  byte write strobe to memory.
- mem_addr  output  32  byte write address.
- mem_byte  output  8  byte write data.
- core_hold  output  1  high holds tinker_core in reset.
- done  output  1  load completed and checksum matched.
- err  output  1  load failed (bounds or checksum).
- instr_count  output  16  instruction count latched from the header.

Behaviour:
- Frame format: LEN_LO, LEN_HI (16-bit instruction count N, little-endian), then 4*N image bytes, then CHK.
  - CHK equals the XOR of all 4*N image bytes; it is 8'h00 when N=0.
- Handshake: a byte transfers on any rising edge where s_valid && s_ready.
  - s_data must be held while s_valid is high and s_ready is low.
  - s_ready is combinational from state: 1 in LEN0, LEN1, DATA and CHK; 0 in DONE and ERR.
- Reset (asynchronous, active-high) puts all outputs to these values:
  - state=LEN0, s_ready=1 once reset is low, mem_we=0, mem_addr=0, mem_byte=0.
  - core_hold=1, done=0, err=0, instr_count=0.
  - Internal byte counter and running XOR cleared.
- State machine:
  - LEN0: accepting a byte latches instr_count[7:0]; go to LEN1.
  - LEN1: accepting a byte latches instr_count[15:8], clears the counter and the XOR.
    - If N==0: go to CHK.
    - Else if BASE_ADDR + 4*N > MEM_SIZE (compute in 33 bits): go to ERR.
    - Else: go to DATA.
  - DATA: each accepted byte is written and XORed into the running XOR, and the counter increments.
    - After the byte where counter == 4*N-1: go to CHK.
  - CHK: accepting a byte compares it with the running XOR.
    - Equal: go to DONE.
    - Unequal: go to ERR.
  - DONE: done=1, core_hold=0. Stays here until restart.
  - ERR: err=1, core_hold=1. Stays here until restart.
  - restart in DONE or ERR goes to LEN0 on the next edge.
    - done, err and instr_count are cleared.
    - core_hold returns to 1 on that same edge.
    - restart is ignored in every other state.
- Write timing (outputs registered, one-cycle latency):
  - A DATA-state acceptance at edge k gives mem_we=1, mem_addr=BASE_ADDR+counter, mem_byte=s_data during cycle k+1.
  - mem_we=0 in every other cycle.
  - Back-to-back acceptances produce back-to-back write cycles.
- Byte order: the stream is image byte order. The first byte of each 4-byte group is the instruction's bits [7:0] and lands at the lowest address, so the core's little-endian fetch reassembles it.
- Counter is 18 bits and never wraps within a legal frame; the bounds check guarantees addresses stay below MEM_SIZE.
- done, err and core_hold change on the edge that enters DONE or ERR, so they are visible the cycle after CHK is accepted.
- A gap (s_valid low) in any state holds all state; no timeout.
- Reset asserted mid-load aborts immediately.
  - mem_we drops asynchronously.
  - Bytes already written are not undone.
  - The next frame starts at LEN0.
- done and err are never high together.

Test Plan:
- Single instruction: N=1, bytes 01 00, 78 56 34 12, CHK=0x08.
  - Required: writes 0x78@0x2000, 0x56@0x2001, 0x34@0x2002, 0x12@0x2003 on consecutive cycles.
  - Then done=1, core_hold=0, instr_count=1, and memory little-endian fetch at 0x2000 = 32'h12345678.
- Bad checksum: same frame with CHK=0x09.
  - Required: all four writes occur, then err=1, done=0, core_hold=1, s_ready=0.
  - restart pulse then gives err=0 and the state is back in LEN0.
- Zero length: bytes 00 00 00.
  - Required: no mem_we pulses, done=1 the cycle after CHK is accepted.
  - Zero length with CHK=0x01: err=1.
- Bounds: LEN=0xFFFF (BASE 0x2000 + 262140 <= 524288, legal) proceeds to DATA.
  - With MEM_SIZE=0x2010 and LEN=5: err=1 right after LEN_HI, no writes.
- Backpressure and gaps: N=2, s_valid toggled randomly.
  - Required: exactly 8 writes at 0x2000..0x2007, in order, with correct bytes.
  - s_data is only sampled on handshake.
- Reset mid-load: assert reset after 3 DATA bytes.
  - Required: mem_we=0 immediately and core_hold=1.
  - A subsequent full N=1 frame loads correctly from 0x2000.

Source files
------------

// File: rtl/tinker_prog_loader.sv
// tinker_prog_loader: receives a framed byte stream (LEN_LO, LEN_HI, 4*N image
// bytes, CHK) and writes the image into data memory from BASE_ADDR upward.
// The image bytes are written little-endian, in stream order. The loader keeps
// tinker_core in reset until a full frame has loaded and its XOR checksum matches.
module tinker_prog_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_2000,
    parameter int unsigned MEM_SIZE  = 524288
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        s_valid,
    input  logic [7:0]  s_data,
    output logic        s_ready,
    input  logic        restart,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [7:0]  mem_byte,
    output logic        core_hold,
    output logic        done,
    output logic        err,
    output logic [15:0] instr_count
);

    typedef enum logic [2:0] {
        S_LEN0,
        S_LEN1,
        S_DATA,
        S_CHK,
        S_DONE,
        S_ERR
    } state_t;

    state_t      r_state;
    logic [17:0] r_count;       // byte index within the image, 0 .. 4*N-1
    logic [7:0]  r_xor;         // running XOR of image bytes
    logic [15:0] r_instr_count;
    logic        r_mem_we;
    logic [31:0] r_mem_addr;
    logic [7:0]  r_mem_byte;
    logic        r_core_hold;
    logic        r_done;
    logic        r_err;

    logic        w_accept;
    logic [15:0] w_len_n;       // full instruction count as LEN_HI arrives
    logic [32:0] w_end_addr;    // one past the last image byte, 33 bits so it cannot overflow
    logic        w_oob;
    logic [17:0] w_total;       // image length in bytes
    logic        w_last;

    // The loader is ready in every state that still expects stream bytes.
    assign s_ready  = (r_state == S_LEN0) || (r_state == S_LEN1) ||
                      (r_state == S_DATA) || (r_state == S_CHK);
    assign w_accept = s_valid && s_ready;

    assign w_len_n    = {s_data, r_instr_count[7:0]};
    assign w_end_addr = {1'b0, BASE_ADDR} + {15'd0, w_len_n, 2'b00};
    assign w_oob      = w_end_addr > 33'(MEM_SIZE);
    assign w_total    = {r_instr_count, 2'b00};
    // Only evaluated in DATA, where N >= 1, so the subtraction never underflows.
    assign w_last     = (r_count == (w_total - 18'd1));

    // Frame sequencer: handles the header, the image writes, the checksum and the final status.
    // NOTE: every register here uses non-blocking assignment, so all of them read the
    // pre-edge values of the others. Blocking assignment would make the result depend
    // on statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= S_LEN0;
            r_count       <= '0;
            r_xor         <= '0;
            r_instr_count <= '0;
            r_mem_we      <= 1'b0;
            r_mem_addr    <= '0;
            r_mem_byte    <= '0;
            r_core_hold   <= 1'b1;
            r_done        <= 1'b0;
            r_err         <= 1'b0;
        end else begin
            // The write strobe is a single-cycle pulse unless DATA accepts another byte.
            r_mem_we <= 1'b0;

            case (r_state)
                S_LEN0: begin
                    if (w_accept) begin
                        r_instr_count[7:0] <= s_data;
                        r_state            <= S_LEN1;
                    end
                end

                S_LEN1: begin
                    if (w_accept) begin
                        r_instr_count[15:8] <= s_data;
                        r_count             <= '0;
                        r_xor               <= '0;
                        if (w_len_n == 16'd0) begin
                            r_state <= S_CHK;
                        end else if (w_oob) begin
                            r_state <= S_ERR;
                            r_err   <= 1'b1;
                        end else begin
                            r_state <= S_DATA;
                        end
                    end
                end

                S_DATA: begin
                    if (w_accept) begin
                        r_mem_we   <= 1'b1;
                        r_mem_addr <= BASE_ADDR + {14'd0, r_count};
                        r_mem_byte <= s_data;
                        r_xor      <= r_xor ^ s_data;
                        r_count    <= r_count + 18'd1;
                        if (w_last) begin
                            r_state <= S_CHK;
                        end
                    end
                end

                S_CHK: begin
                    if (w_accept) begin
                        if (s_data == r_xor) begin
                            r_state     <= S_DONE;
                            r_done      <= 1'b1;
                            r_core_hold <= 1'b0;
                        end else begin
                            r_state <= S_ERR;
                            r_err   <= 1'b1;
                        end
                    end
                end

                S_DONE, S_ERR: begin
                    if (restart) begin
                        r_state       <= S_LEN0;
                        r_done        <= 1'b0;
                        r_err         <= 1'b0;
                        r_instr_count <= '0;
                        r_core_hold   <= 1'b1;
                    end
                end

                default: begin
                    r_state <= S_LEN0;
                end
            endcase
        end
    end

    assign mem_we      = r_mem_we;
    assign mem_addr    = r_mem_addr;
    assign mem_byte    = r_mem_byte;
    assign core_hold   = r_core_hold;
    assign done        = r_done;
    assign err         = r_err;
    assign instr_count = r_instr_count;

endmodule

// File: tb/tb_tinker_prog_loader.sv
// Testbench for tinker_prog_loader. A scoreboard queue holds the expected memory
// writes, and the status outputs are compared against directed expectations.
module tb_tinker_prog_loader;

    typedef struct packed {
        logic [31:0] addr;
        logic [7:0]  data;
    } wr_t;

    logic        clk;
    logic        reset;
    logic        s_valid;
    logic [7:0]  s_data;
    logic        s_ready;
    logic        restart;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [7:0]  mem_byte;
    logic        core_hold;
    logic        done;
    logic        err;
    logic [15:0] instr_count;

    // Second instance, with a small memory, for the out-of-bounds check.
    logic        s_valid2;
    logic [7:0]  s_data2;
    logic        s_ready2;
    logic        restart2;
    logic        mem_we2;
    logic [31:0] mem_addr2;
    logic [7:0]  mem_byte2;
    logic        core_hold2;
    logic        done2;
    logic        err2;
    logic [15:0] instr_count2;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int n_writes = 0;
    int n_writes2 = 0;
    int w_before;
    wr_t exp_q[$];
    int wr_cyc[$];
    logic [7:0] tb_mem [logic [31:0]];

    tinker_prog_loader #(.BASE_ADDR(32'h2000), .MEM_SIZE(524288)) dut (
        .clk(clk), .reset(reset), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .restart(restart), .mem_we(mem_we), .mem_addr(mem_addr), .mem_byte(mem_byte),
        .core_hold(core_hold), .done(done), .err(err), .instr_count(instr_count)
    );

    tinker_prog_loader #(.BASE_ADDR(32'h2000), .MEM_SIZE(32'h2010)) dut_small (
        .clk(clk), .reset(reset), .s_valid(s_valid2), .s_data(s_data2), .s_ready(s_ready2),
        .restart(restart2), .mem_we(mem_we2), .mem_addr(mem_addr2), .mem_byte(mem_byte2),
        .core_hold(core_hold2), .done(done2), .err(err2), .instr_count(instr_count2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        check(tag, {31'd0, obs}, {31'd0, exp});
    endtask

    // Write monitor: pops one expected write per observed strobe and mirrors memory.
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            n_writes++;
            wr_cyc.push_back(cyc);
            tb_mem[mem_addr] = mem_byte;
            if (exp_q.size() == 0) begin
                check_bit("unexpected_write", mem_we, 1'b0);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("wr_addr", mem_addr, e.addr);
                check("wr_byte", {24'd0, mem_byte}, {24'd0, e.data});
            end
        end
        if (mem_we2 === 1'b1) n_writes2++;
    end

    // Offers one byte, optionally after a random idle gap filled with junk data, and waits for the handshake.
    task automatic send_byte(input logic [7:0] b, input int max_gap);
        int gap;
        bit rdy;
        bit accepted;
        gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
        accepted = 1'b0;
        repeat (gap) begin
            s_valid = 1'b0;
            s_data  = 8'($urandom);
            @(posedge clk); #1;
        end
        s_valid = 1'b1;
        s_data  = b;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            rdy = s_ready;
            @(posedge clk); #1;
            if (rdy) begin
                accepted = 1'b1;
                break;
            end
        end
        s_valid = 1'b0;
        s_data  = 8'($urandom);
        if (!accepted) check_bit("handshake_timeout", 1'b0, 1'b1);
    endtask

    task automatic send_data(input logic [7:0] b, input logic [31:0] addr, input bit expect_wr, input int max_gap);
        wr_t e;
        e.addr = addr;
        e.data = b;
        if (expect_wr) exp_q.push_back(e);
        send_byte(b, max_gap);
    endtask

    task automatic pulse_restart();
        restart = 1'b1;
        @(posedge clk); #1;
        restart = 1'b0;
    endtask

    // The small instance is only ever ready in the states these bytes are sent in.
    task automatic send2(input logic [7:0] b);
        s_valid2 = 1'b1;
        s_data2  = b;
        @(posedge clk); #1;
        s_valid2 = 1'b0;
    endtask

    function automatic logic [31:0] fetch(input logic [31:0] a);
        return {tb_mem[a + 3], tb_mem[a + 2], tb_mem[a + 1], tb_mem[a]};
    endfunction

    initial begin
        reset    = 1'b1;
        s_valid  = 1'b0;
        s_data   = 8'h00;
        restart  = 1'b0;
        s_valid2 = 1'b0;
        s_data2  = 8'h00;
        restart2 = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // Reset state
        check_bit("rst_mem_we", mem_we, 1'b0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_mem_byte", {24'd0, mem_byte}, 32'h0);
        check_bit("rst_core_hold", core_hold, 1'b1);
        check_bit("rst_done", done, 1'b0);
        check_bit("rst_err", err, 1'b0);
        check("rst_instr_count", {16'd0, instr_count}, 32'h0);
        @(negedge clk) reset = 1'b0;
        @(posedge clk); #1;
        check_bit("rst_s_ready", s_ready, 1'b1);

        // Single instruction, back to back
        w_before = n_writes;
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        send_data(8'h78, 32'h2000, 1'b1, 0);
        send_data(8'h56, 32'h2001, 1'b1, 0);
        send_data(8'h34, 32'h2002, 1'b1, 0);
        send_data(8'h12, 32'h2003, 1'b1, 0);
        send_byte(8'h08, 0);
        check_bit("t1_done", done, 1'b1);
        check_bit("t1_err", err, 1'b0);
        check_bit("t1_core_hold", core_hold, 1'b0);
        check_bit("t1_s_ready", s_ready, 1'b0);
        check("t1_instr_count", {16'd0, instr_count}, 32'd1);
        check("t1_nwrites", n_writes - w_before, 32'd4);
        check("t1_queue_left", exp_q.size(), 32'd0);
        check("t1_consecutive", wr_cyc[wr_cyc.size() - 1] - wr_cyc[wr_cyc.size() - 4], 32'd3);
        check("t1_fetch", fetch(32'h2000), 32'h1234_5678);
        pulse_restart();
        check_bit("t1_rs_done", done, 1'b0);
        check_bit("t1_rs_core_hold", core_hold, 1'b1);
        check_bit("t1_rs_s_ready", s_ready, 1'b1);
        check("t1_rs_instr_count", {16'd0, instr_count}, 32'd0);

        // Bad checksum
        w_before = n_writes;
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        send_data(8'h78, 32'h2000, 1'b1, 0);
        send_data(8'h56, 32'h2001, 1'b1, 0);
        send_data(8'h34, 32'h2002, 1'b1, 0);
        send_data(8'h12, 32'h2003, 1'b1, 0);
        send_byte(8'h09, 0);
        check_bit("t2_err", err, 1'b1);
        check_bit("t2_done", done, 1'b0);
        check_bit("t2_core_hold", core_hold, 1'b1);
        check_bit("t2_s_ready", s_ready, 1'b0);
        check("t2_nwrites", n_writes - w_before, 32'd4);
        pulse_restart();
        check_bit("t2_rs_err", err, 1'b0);
        check_bit("t2_rs_s_ready", s_ready, 1'b1);

        // Zero length; a restart pulse mid-header must be ignored
        w_before = n_writes;
        send_byte(8'h00, 0);
        pulse_restart();
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        check_bit("t3_done", done, 1'b1);
        check_bit("t3_core_hold", core_hold, 1'b0);
        check("t3_nwrites", n_writes - w_before, 32'd0);
        pulse_restart();
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        send_byte(8'h01, 0);
        check_bit("t3b_err", err, 1'b1);
        check_bit("t3b_done", done, 1'b0);
        check("t3b_nwrites", n_writes - w_before, 32'd0);
        pulse_restart();

        // Backpressure and gaps: N=2 with random idle cycles and junk data between bytes
        w_before = n_writes;
        send_byte(8'h02, 3);
        send_byte(8'h00, 3);
        send_data(8'h11, 32'h2000, 1'b1, 3);
        send_data(8'h22, 32'h2001, 1'b1, 3);
        send_data(8'h33, 32'h2002, 1'b1, 3);
        send_data(8'h44, 32'h2003, 1'b1, 3);
        send_data(8'h55, 32'h2004, 1'b1, 3);
        send_data(8'h66, 32'h2005, 1'b1, 3);
        send_data(8'h77, 32'h2006, 1'b1, 3);
        send_data(8'h88, 32'h2007, 1'b1, 3);
        send_byte(8'h88, 3);
        check_bit("t4_done", done, 1'b1);
        check("t4_instr_count", {16'd0, instr_count}, 32'd2);
        check("t4_nwrites", n_writes - w_before, 32'd8);
        check("t4_queue_left", exp_q.size(), 32'd0);
        check("t4_fetch0", fetch(32'h2000), 32'h4433_2211);
        check("t4_fetch1", fetch(32'h2004), 32'h8877_6655);
        pulse_restart();

        // Largest legal length enters DATA, then reset aborts after three data bytes
        send_byte(8'hFF, 0);
        send_byte(8'hFF, 0);
        check_bit("t5_err", err, 1'b0);
        check_bit("t5_s_ready", s_ready, 1'b1);
        check("t5_instr_count", {16'd0, instr_count}, 32'h0000_FFFF);
        send_data(8'hA1, 32'h2000, 1'b1, 0);
        send_data(8'hB2, 32'h2001, 1'b1, 0);
        send_data(8'hC3, 32'h2002, 1'b0, 0);
        #1 reset = 1'b1;
        #1;
        check_bit("t5_rst_mem_we", mem_we, 1'b0);
        check_bit("t5_rst_core_hold", core_hold, 1'b1);
        check("t5_queue_left", exp_q.size(), 32'd0);
        @(negedge clk) reset = 1'b0;
        @(posedge clk); #1;
        check_bit("t5_post_s_ready", s_ready, 1'b1);
        check("t5_post_instr_count", {16'd0, instr_count}, 32'd0);

        // A full frame after the abort loads from BASE_ADDR
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        send_data(8'hEF, 32'h2000, 1'b1, 1);
        send_data(8'hBE, 32'h2001, 1'b1, 1);
        send_data(8'hAD, 32'h2002, 1'b1, 1);
        send_data(8'hDE, 32'h2003, 1'b1, 1);
        send_byte(8'h22, 0);
        check_bit("t6_done", done, 1'b1);
        check("t6_queue_left", exp_q.size(), 32'd0);
        check("t6_fetch", fetch(32'h2000), 32'hDEAD_BEEF);

        // Bounds on the small instance: LEN=5 overflows, LEN=4 ends exactly at MEM_SIZE
        send2(8'h05);
        send2(8'h00);
        check_bit("t7_err", err2, 1'b1);
        check_bit("t7_done", done2, 1'b0);
        check_bit("t7_core_hold", core_hold2, 1'b1);
        check_bit("t7_s_ready", s_ready2, 1'b0);
        check("t7_nwrites", n_writes2, 32'd0);
        restart2 = 1'b1;
        @(posedge clk); #1;
        restart2 = 1'b0;
        send2(8'h04);
        send2(8'h00);
        check_bit("t7b_err", err2, 1'b0);
        check_bit("t7b_s_ready", s_ready2, 1'b1);

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
